// File: rtl/score_keeper.sv
// Two-player match scorer: counts rising-edge points, holds play after each point,
// and latches the winner until new_game or reset.
module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       new_game,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       serve_hold
);

  localparam int                CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          p1_prev, p2_prev;
  logic          p1_ev, p2_ev;
  logic [CW-1:0] hold_cnt, hold_cnt_nx;
  logic [3:0]    p1_nx, p2_nx;
  logic [3:0]    p1_inc, p2_inc;
  logic [1:0]    winner_nx;

  assign p1_ev  = p1_point & ~p1_prev;
  assign p2_ev  = p2_point & ~p2_prev;
  assign p1_inc = p1_score + 4'd1;
  assign p2_inc = p2_score + 4'd1;

  // new_game outranks everything, so a point arriving with it is simply dropped
  always_comb begin
    state_nx    = state;
    p1_nx       = p1_score;
    p2_nx       = p2_score;
    winner_nx   = winner;
    hold_cnt_nx = hold_cnt;

    if (new_game) begin
      state_nx    = PLAY;
      p1_nx       = 4'd0;
      p2_nx       = 4'd0;
      winner_nx   = 2'd0;
      hold_cnt_nx = '0;
    end else begin
      case (state)
        PLAY: begin
          if (p1_ev && p2_ev) begin
            state_nx    = HOLD;
            hold_cnt_nx = '0;
          end else if (p1_ev) begin
            p1_nx = p1_inc;
            if (p1_inc == WIN) begin
              winner_nx = 2'd1;
              state_nx  = OVER;
            end else begin
              state_nx    = HOLD;
              hold_cnt_nx = '0;
            end
          end else if (p2_ev) begin
            p2_nx = p2_inc;
            if (p2_inc == WIN) begin
              winner_nx = 2'd2;
              state_nx  = OVER;
            end else begin
              state_nx    = HOLD;
              hold_cnt_nx = '0;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx    = PLAY;
            hold_cnt_nx = '0;
          end else begin
            hold_cnt_nx = hold_cnt + CW'(1);
          end
        end
        OVER: begin
          state_nx = OVER;
        end
        default: begin
          state_nx = PLAY;
        end
      endcase
    end
  end

  // Flags are derived from the next state so every output comes straight off a flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PLAY;
      p1_prev    <= 1'b0;
      p2_prev    <= 1'b0;
      hold_cnt   <= '0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      winner     <= 2'd0;
      game_over  <= 1'b0;
      serve_hold <= 1'b0;
    end else begin
      state      <= state_nx;
      p1_prev    <= p1_point;
      p2_prev    <= p2_point;
      hold_cnt   <= hold_cnt_nx;
      p1_score   <= p1_nx;
      p2_score   <= p2_nx;
      winner     <= winner_nx;
      game_over  <= (state_nx == OVER);
      serve_hold <= (state_nx == HOLD);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_score_keeper;

  logic       clk;
  logic       reset_n;
  logic       p1_point;
  logic       p2_point;
  logic       new_game;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic       game_over;
  logic       serve_hold;

  typedef struct {
    string      name;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] w;
    logic       go;
    logic       sh;
    int         at;
  } exp_t;

  exp_t expq[$];
  int   cyc      = 0;
  int   compared = 0;
  int   failed   = 0;

  score_keeper #(
    .WIN_SCORE  (7),
    .HOLD_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p1_point  (p1_point),
    .p2_point  (p2_point),
    .new_game  (new_game),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .winner    (winner),
    .game_over (game_over),
    .serve_hold(serve_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable at negedge, pop every expectation due this cycle
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    while (expq.size() > 0 && expq[0].at <= cyc) begin
      e = expq.pop_front();
      compared++;
      if (p1_score !== e.s1 || p2_score !== e.s2 || winner !== e.w ||
          game_over !== e.go || serve_hold !== e.sh) begin
        failed++;
        $display("[TB] FAIL %s @cyc %0d: got s1=%0d s2=%0d w=%0d go=%0b sh=%0b, want s1=%0d s2=%0d w=%0d go=%0b sh=%0b",
                 e.name, cyc, p1_score, p2_score, winner, game_over, serve_hold,
                 e.s1, e.s2, e.w, e.go, e.sh);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic ng);
    p1_point = a;
    p2_point = b;
    new_game = ng;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [1:0] w, input logic go, input logic sh);
    exp_t e;
    e.name = name;
    e.s1   = s1;
    e.s2   = s2;
    e.w    = w;
    e.go   = go;
    e.sh   = sh;
    e.at   = cyc + 1;
    expq.push_back(e);
  endtask

  // Remaining three hold cycles after a scoring edge, then the release cycle
  task automatic holdOut(input string name, input logic [3:0] s1, input logic [3:0] s2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(name, s1, s2, 2'd0, 1'b0, (i < 3));
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    compared++;
    if (p1_score !== 4'd0 || p2_score !== 4'd0 || winner !== 2'd0 ||
        game_over !== 1'b0 || serve_hold !== 1'b0) begin
      failed++;
      $display("[TB] FAIL power_on_reset: got s1=%0d s2=%0d w=%0d go=%0b sh=%0b, want all 0",
               p1_score, p2_score, winner, game_over, serve_hold);
    end
    checkOutput("reset", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    checkOutput("idle", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();

    $display("[TB] single point with held input");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("p1_held", 4'd1, 4'd0, 2'd0, 1'b0, (i < 4));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("p1_release", 4'd1, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();

    $display("[TB] hold blocks points");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("p1_second", 4'd2, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("p2_in_hold", 4'd2, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_2", 4'd2, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("hold_3", 4'd2, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("hold_end", 4'd2, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("p2_fresh", 4'd2, 4'd1, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("p2_hold", 4'd2, 4'd1);

    $display("[TB] simultaneous edges");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("let", 4'd2, 4'd1, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("let_hold", 4'd2, 4'd1);

    $display("[TB] P2 runs to win");
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("p2_run", 4'd2, 4'(k), (k == 7) ? 2'd2 : 2'd0, (k == 7), (k != 7));
      tick();
      if (k < 7) holdOut("p2_run_hold", 4'd2, 4'(k));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("over_idle", 4'd2, 4'd7, 2'd2, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("over_frozen", 4'd2, 4'd7, 2'd2, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("over_frozen2", 4'd2, 4'd7, 2'd2, 1'b1, 1'b0);
    tick();

    $display("[TB] new_game priority");
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ng_clear", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    checkOutput("ng_held", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ng_done", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ng_p1", 4'd1, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("ng_p1_hold", 4'd1, 4'd0);

    $display("[TB] reset mid-hold");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("to_3_2", 4'd2, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("to_3_2", 4'd2, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("to_3_2", 4'd3, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("to_3_2", 4'd3, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("to_3_2", 4'd3, 4'd1, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("to_3_2", 4'd3, 4'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("at_3_2", 4'd3, 4'd2, 2'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("at_3_2_hold", 4'd3, 4'd2, 2'd0, 1'b0, 1'b1);
    tick();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if (p1_score !== 4'd0) begin
      failed++;
      $display("[TB] FAIL async_p1: got %0d, want 0", p1_score);
    end
    compared++;
    if (p2_score !== 4'd0) begin
      failed++;
      $display("[TB] FAIL async_p2: got %0d, want 0", p2_score);
    end
    compared++;
    if (winner !== 2'd0 || game_over !== 1'b0) begin
      failed++;
      $display("[TB] FAIL async_winner: got w=%0d go=%0b, want w=0 go=0", winner, game_over);
    end
    compared++;
    if (serve_hold !== 1'b0) begin
      failed++;
      $display("[TB] FAIL async_hold: got %0b, want 0", serve_hold);
    end
    checkOutput("async_reset", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    checkOutput("post_reset", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_p1", 4'd1, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    holdOut("post_reset_hold", 4'd1, 4'd0);

    tick();
    tick();
    while (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      compared++;
      failed++;
      $display("[TB] FAIL %s: got no check, want check at cyc %0d", e.name, e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
